cache_mem_bridge: RTL and testbench

Downstream stage of the cache's refill/writeback port. It accepts line-refill read requests (`rd_req`) and line-writeback requests (`wr_req` plus a full line of data). It converts them into single-word transactions on a simple request/`addr_ok`/`data_ok` memory bus. It holds one writeback line in an internal write buffer and returns refill words to the cache as a `ret_valid`/`ret_last` beat stream.

---
 rtl/cache_mem_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_cache_mem_bridge.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge
//   Converts cache line refills and line writebacks into single-word
//   transactions on a request / addr_ok / data_ok memory bus. One writeback
//   line is buffered internally; refill words stream back to the cache as
//   ret_valid / ret_last beats. Only one bus transaction is in flight at a time,
//   and reads take priority over writes.
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   rd_req/rd_addr/rd_rdy            refill request handshake
//   ret_valid/ret_last/ret_data      refill word stream (no backpressure)
//   wr_req/wr_addr/wr_data/wr_rdy    writeback request handshake (full line)
//   mem_req/mem_wr/mem_addr/mem_wdata  word request to memory
//   mem_addr_ok/mem_data_ok/mem_rdata  memory accept / completion / read data
module cache_mem_bridge #(
   parameter int BYTES_PER_LINE = 64,
   parameter int WORDS_PER_LINE = BYTES_PER_LINE / 4,
   parameter int LINE_WIDTH     = WORDS_PER_LINE * 32,
   parameter int OFFSET_WIDTH   = $clog2(BYTES_PER_LINE)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  rd_req,
   input  logic [31:0]           rd_addr,
   output logic                  rd_rdy,
   output logic                  ret_valid,
   output logic                  ret_last,
   output logic [31:0]           ret_data,
   input  logic                  wr_req,
   input  logic [31:0]           wr_addr,
   input  logic [LINE_WIDTH-1:0] wr_data,
   output logic                  wr_rdy,
   output logic                  mem_req,
   output logic                  mem_wr,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_addr_ok,
   input  logic                  mem_data_ok,
   input  logic [31:0]           mem_rdata
);

   localparam int CNT_W = $clog2(WORDS_PER_LINE);
   localparam int TAG_W = 32 - OFFSET_WIDTH;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_REQ  = 3'd3,
      S_WR_WAIT = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic                  rd_pend_q, rd_pend_d;
   logic [TAG_W-1:0]      rd_line_q, rd_line_d;
   logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
   logic                  wbuf_valid_q, wbuf_valid_d;
   logic [TAG_W-1:0]      wbuf_line_q, wbuf_line_d;
   logic [LINE_WIDTH-1:0] wbuf_data_q, wbuf_data_d;
   logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;

   logic                  rd_hit_wbuf_s;
   logic                  rd_accept_s;
   logic                  wr_accept_s;
   logic [LINE_WIDTH-1:0] wbuf_shift_s;
   logic                  unused_s;

   // The line offset bits of both request addresses are deliberately ignored.
   assign unused_s = ^{rd_addr[OFFSET_WIDTH-1:0], wr_addr[OFFSET_WIDTH-1:0]};

   // A refill of the line still sitting in the write buffer must wait until
   // the buffer drains, otherwise it would read stale memory.
   assign rd_hit_wbuf_s = wbuf_valid_q && (rd_addr[31:OFFSET_WIDTH] == wbuf_line_q);
   assign rd_rdy        = !rd_pend_q && !rd_hit_wbuf_s;
   assign wr_rdy        = !wbuf_valid_q;
   assign rd_accept_s   = rd_req && rd_rdy;
   assign wr_accept_s   = wr_req && wr_rdy;

   // Current write word sits at the bottom of the shifted line.
   assign wbuf_shift_s  = wbuf_data_q >> {wr_cnt_q, 5'b00000};

   // Next-state, request acceptance and bus/return outputs.
   always_comb begin
      state_d      = state_q;
      rd_pend_d    = rd_pend_q;
      rd_line_d    = rd_line_q;
      rd_cnt_d     = rd_cnt_q;
      wbuf_valid_d = wbuf_valid_q;
      wbuf_line_d  = wbuf_line_q;
      wbuf_data_d  = wbuf_data_q;
      wr_cnt_d     = wr_cnt_q;
      mem_req      = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = 32'h0000_0000;
      mem_wdata    = 32'h0000_0000;
      ret_valid    = 1'b0;
      ret_last     = 1'b0;
      ret_data     = 32'h0000_0000;

      // Acceptance never collides with completion below: a read is only
      // accepted with no read pending, a write only with the buffer empty.
      if (rd_accept_s) begin
         rd_pend_d = 1'b1;
         rd_line_d = rd_addr[31:OFFSET_WIDTH];
         rd_cnt_d  = {CNT_W{1'b0}};
      end else begin
         rd_pend_d = rd_pend_q;
      end

      if (wr_accept_s) begin
         wbuf_valid_d = 1'b1;
         wbuf_line_d  = wr_addr[31:OFFSET_WIDTH];
         wbuf_data_d  = wr_data;
         wr_cnt_d     = {CNT_W{1'b0}};
      end else begin
         wbuf_valid_d = wbuf_valid_q;
      end

      case (state_q)
         S_IDLE: begin
            if (rd_pend_q) begin
               state_d = S_RD_REQ;
            end else if (wbuf_valid_q) begin
               state_d = S_WR_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD_REQ: begin
            mem_req  = 1'b1;
            mem_addr = {rd_line_q, rd_cnt_q, 2'b00};
            if (mem_addr_ok) begin
               state_d = S_RD_WAIT;
            end else begin
               state_d = S_RD_REQ;
            end
         end
         S_RD_WAIT: begin
            if (mem_data_ok) begin
               ret_valid = 1'b1;
               ret_data  = mem_rdata;
               ret_last  = (rd_cnt_q == LAST_WORD);
               if (rd_cnt_q == LAST_WORD) begin
                  rd_pend_d = 1'b0;
                  rd_cnt_d  = {CNT_W{1'b0}};
                  state_d   = S_IDLE;
               end else begin
                  rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                  state_d   = S_RD_REQ;
               end
            end else begin
               state_d = S_RD_WAIT;
            end
         end
         S_WR_REQ: begin
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = {wbuf_line_q, wr_cnt_q, 2'b00};
            mem_wdata = wbuf_shift_s[31:0];
            if (mem_addr_ok) begin
               state_d = S_WR_WAIT;
            end else begin
               state_d = S_WR_REQ;
            end
         end
         S_WR_WAIT: begin
            // Back to IDLE after every write word so a pending refill can
            // slip in between writeback words.
            if (mem_data_ok) begin
               state_d = S_IDLE;
               if (wr_cnt_q == LAST_WORD) begin
                  wbuf_valid_d = 1'b0;
                  wr_cnt_d     = {CNT_W{1'b0}};
               end else begin
                  wr_cnt_d     = wr_cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = S_WR_WAIT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Read tracker and write buffer registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_pend_q    <= 1'b0;
         rd_line_q    <= {TAG_W{1'b0}};
         rd_cnt_q     <= {CNT_W{1'b0}};
         wbuf_valid_q <= 1'b0;
         wbuf_line_q  <= {TAG_W{1'b0}};
         wbuf_data_q  <= {LINE_WIDTH{1'b0}};
         wr_cnt_q     <= {CNT_W{1'b0}};
      end else begin
         rd_pend_q    <= rd_pend_d;
         rd_line_q    <= rd_line_d;
         rd_cnt_q     <= rd_cnt_d;
         wbuf_valid_q <= wbuf_valid_d;
         wbuf_line_q  <= wbuf_line_d;
         wbuf_data_q  <= wbuf_data_d;
         wr_cnt_q     <= wr_cnt_d;
      end
   end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Bench for cache_mem_bridge: a randomly stalling memory responder, a
// line-level reference memory, and queues of expected bus words and refill beats.
module tb_cache_mem_bridge;

   localparam int BPL = 64;
   localparam int WPL = BPL / 4;
   localparam int LW  = WPL * 32;

   logic          clk = 1'b0;
   logic          resetn;
   logic          rd_req, wr_req;
   logic [31:0]   rd_addr, wr_addr;
   logic [LW-1:0] wr_data;
   logic          rd_rdy, wr_rdy, ret_valid, ret_last;
   logic [31:0]   ret_data;
   logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [31:0]   mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   cache_mem_bridge #(.BYTES_PER_LINE(BPL)) dut (
      .clk(clk), .resetn(resetn),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference state: line-level memory contents and expected traffic.
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] bus_mem [logic [31:0]];
   logic [32:0] exp_ret_q [$];   // {last, data}
   logic [31:0] exp_rd_q  [$];   // read word addresses in order
   logic [63:0] exp_wr_q  [$];   // {addr, data} write words in order
   int          beat_cyc_q [$];

   int ncyc = 0;
   int beats = 0;
   int last_ret_cyc = -1;
   int first_wr_cyc = -1;
   int last_wr_dok_cyc = -1;
   bit stall_en = 1'b0;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] bus_word(input logic [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
   endfunction

   always @(posedge clk) ncyc <= ncyc + 1;

   // Refill beat monitor.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (ret_valid === 1'b1) begin
            beats++;
            last_ret_cyc = ncyc;
            beat_cyc_q.push_back(ncyc);
            if (exp_ret_q.size() == 0) begin
               check_eq("ret_unexpected_beat", 32'(exp_ret_q.size()), 32'd1);
            end else begin
               e = exp_ret_q.pop_front();
               check_eq("ret_data", ret_data, e[31:0]);
               check_eq("ret_last", 32'(ret_last), 32'(e[32]));
            end
         end else begin
            check_eq("ret_last_idle", 32'(ret_last), 32'd0);
         end
      end
   end

   // Memory responder with optional random addr_ok / data_ok delays.
   int          rs = 0;
   int          acnt, dcnt;
   logic [31:0] l_addr, l_wdata;
   logic        l_wr;

   task automatic bus_accept();
      logic [63:0] w;
      mem_addr_ok = 1'b1;
      rs   = 2;
      dcnt = stall_en ? int'($urandom_range(1, 7)) : 1;
      if (l_wr) begin
         if (first_wr_cyc < 0) first_wr_cyc = ncyc;
         if (exp_wr_q.size() == 0) begin
            check_eq("bus_unexpected_wr", 32'(exp_wr_q.size()), 32'd1);
         end else begin
            w = exp_wr_q.pop_front();
            check_eq("wr_addr", l_addr, w[63:32]);
            check_eq("wr_data", l_wdata, w[31:0]);
         end
      end else begin
         if (exp_rd_q.size() == 0) begin
            check_eq("bus_unexpected_rd", 32'(exp_rd_q.size()), 32'd1);
         end else begin
            check_eq("rd_addr", l_addr, exp_rd_q.pop_front());
         end
      end
   endtask

   initial begin
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = 32'h0000_0000;
      forever begin
         @(negedge clk);
         mem_addr_ok = 1'b0;
         mem_data_ok = 1'b0;
         mem_rdata   = $urandom;
         if (resetn !== 1'b1) begin
            rs = 0;
         end else begin
            case (rs)
               0: begin
                  if (mem_req === 1'b1) begin
                     l_addr  = mem_addr;
                     l_wr    = mem_wr;
                     l_wdata = mem_wdata;
                     acnt    = stall_en ? int'($urandom_range(0, 5)) : 0;
                     if (acnt == 0) bus_accept();
                     else rs = 1;
                  end
               end
               1: begin
                  check_eq("mem_req_stable", 32'(mem_req), 32'd1);
                  check_eq("mem_wr_stable", 32'(mem_wr), 32'(l_wr));
                  check_eq("mem_addr_stable", mem_addr, l_addr);
                  check_eq("mem_wdata_stable", mem_wdata, l_wdata);
                  acnt--;
                  if (acnt == 0) bus_accept();
               end
               2: begin
                  dcnt--;
                  if (dcnt == 0) begin
                     mem_data_ok = 1'b1;
                     if (l_wr) begin
                        bus_mem[l_addr] = l_wdata;
                        last_wr_dok_cyc = ncyc;
                     end else begin
                        mem_rdata = bus_word(l_addr);
                     end
                     rs = 0;
                  end
               end
               default: rs = 0;
            endcase
         end
      end
   end

   // Present a read and/or write request and hold until each is accepted.
   task automatic issue(input bit do_rd, input bit do_wr, input logic [31:0] ra,
                        input logic [31:0] wa, input logic [LW-1:0] wd,
                        output int rd_acc, output int wr_acc);
      bit rd_done, wr_done;
      int n;
      logic [31:0] base;
      rd_done = !do_rd; wr_done = !do_wr; n = 0; rd_acc = -1; wr_acc = -1;
      @(negedge clk);
      rd_req = do_rd; rd_addr = ra; wr_req = do_wr; wr_addr = wa; wr_data = wd;
      forever begin
         #1;
         // Read expectations are taken before a same-cycle write updates the model.
         if (!rd_done && rd_rdy) begin
            rd_done = 1'b1; rd_acc = ncyc;
            base = {ra[31:6], 6'b000000};
            for (int i = 0; i < WPL; i++) begin
               exp_rd_q.push_back(base + 32'(4 * i));
               exp_ret_q.push_back({(i == WPL - 1), ref_word(base + 32'(4 * i))});
            end
         end
         if (!wr_done && wr_rdy) begin
            wr_done = 1'b1; wr_acc = ncyc;
            base = {wa[31:6], 6'b000000};
            for (int i = 0; i < WPL; i++) begin
               exp_wr_q.push_back({base + 32'(4 * i), wd[32*i +: 32]});
               ref_mem[base + 32'(4 * i)] = wd[32*i +: 32];
            end
         end
         @(posedge clk);
         #1;
         if (rd_done) rd_req = 1'b0;
         if (wr_done) wr_req = 1'b0;
         if (rd_done && wr_done) break;
         n++;
         if (n > 3000) begin
            check_eq("handshake_timeout", 32'(n), 32'd0);
            rd_req = 1'b0; wr_req = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_idle();
      int  n;
      bit  busy;
      n = 0;
      do begin
         @(negedge clk); #2; n++;
         busy = (exp_ret_q.size() != 0) || (exp_rd_q.size() != 0) ||
                (exp_wr_q.size() != 0) || !rd_rdy || !wr_rdy || mem_req;
      end while (busy && n < 20000);
      check_eq("drain_busy", 32'(busy), 32'd0);
   endtask

   task automatic check_reset_outs();
      check_eq("rst_mem_req", 32'(mem_req), 32'd0);
      check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
      check_eq("rst_ret_valid", 32'(ret_valid), 32'd0);
      check_eq("rst_ret_last", 32'(ret_last), 32'd0);
      check_eq("rst_rd_rdy", 32'(rd_rdy), 32'd1);
      check_eq("rst_wr_rdy", 32'(wr_rdy), 32'd1);
      check_eq("rst_mem_addr", mem_addr, 32'h0);
      check_eq("rst_mem_wdata", mem_wdata, 32'h0);
      check_eq("rst_ret_data", ret_data, 32'h0);
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int i = 0; i < WPL; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ra, wa, ra2, wa2, n;
      logic [LW-1:0] wd;
      logic [31:0] a1, a2;
      resetn = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
      rd_addr = 32'h0; wr_addr = 32'h0; wr_data = '0;
      repeat (2) @(negedge clk);
      #1 check_reset_outs();
      @(negedge clk); resetn = 1'b1;

      // Refill only, zero-wait memory: addresses, data, last flag and latency.
      beat_cyc_q.delete();
      issue(1'b1, 1'b0, 32'h0000_1234, 32'h0, '0, ra, wa);
      wait_idle();
      check_eq("t1_beats", 32'(beat_cyc_q.size()), 32'd16);
      if (beat_cyc_q.size() == 16) begin
         check_eq("t1_first_latency", 32'(beat_cyc_q[0] - ra), 32'd3);
         check_eq("t1_burst_span", 32'(beat_cyc_q[15] - beat_cyc_q[0]), 32'd30);
      end
      check_eq("t1_rd_rdy_after", 32'(rd_rdy), 32'd1);

      // Writeback only; a second writeback measures when wr_rdy returns.
      for (int i = 0; i < WPL; i++) wd[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
      issue(1'b0, 1'b1, 32'h0, 32'h8000_0040, wd, ra, wa);
      issue(1'b0, 1'b1, 32'h0, 32'h8000_0080, rand_line(), ra2, wa2);
      check_eq("t2_wr_rdy_rise", 32'(wa2), 32'(last_wr_dok_cyc + 1));
      wait_idle();

      // Simultaneous handshake: read burst entirely before any write word.
      first_wr_cyc = -1;
      issue(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0100, rand_line(), ra, wa);
      check_eq("t3_same_cycle", 32'(ra), 32'(wa));
      wait_idle();
      check_eq("t3_rd_before_wr", 32'(first_wr_cyc > last_ret_cyc), 32'd1);

      // Read-after-write hazard on the buffered line.
      issue(1'b0, 1'b1, 32'h0, 32'h0000_0300, rand_line(), ra, wa);
      @(negedge clk); rd_addr = 32'h0000_0310; #1;
      check_eq("t4_rd_rdy_blocked", 32'(rd_rdy), 32'd0);
      issue(1'b1, 1'b0, 32'h0000_0310, 32'h0, '0, ra, wa);
      check_eq("t4_rd_accept_cycle", 32'(ra), 32'(last_wr_dok_cyc + 1));
      wait_idle();

      // Random traffic against a stalling memory.
      stall_en = 1'b1;
      for (int it = 0; it < 14; it++) begin
         int op;
         op = int'($urandom_range(0, 2));
         a1 = 32'h0000_2000 + 32'(64 * $urandom_range(0, 3)) + 32'($urandom_range(0, 63));
         a2 = 32'h0000_2000 + 32'(64 * $urandom_range(0, 3)) + 32'($urandom_range(0, 63));
         if (op == 2 && a1[31:6] == a2[31:6]) a2 = a2 + 32'd64;
         issue(op != 1, op != 0, a1, a2, rand_line(), ra, wa);
      end
      wait_idle();
      stall_en = 1'b0;

      // Reset in the middle of a refill burst.
      beats = 0;
      issue(1'b1, 1'b0, 32'h0000_0500, 32'h0, '0, ra, wa);
      n = 0;
      while (beats < 5 && n < 200) begin @(negedge clk); #2; n++; end
      check_eq("t6_reach_word5", 32'(beats >= 5), 32'd1);
      @(negedge clk); #2;
      resetn = 1'b0;
      #1 check_reset_outs();
      exp_ret_q.delete(); exp_rd_q.delete(); exp_wr_q.delete();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      beats = 0;
      issue(1'b1, 1'b0, 32'h0000_0400, 32'h0, '0, ra, wa);
      wait_idle();
      check_eq("t6_beats_after_reset", 32'(beats), 32'd16);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
